reg_file_mp: RTL and testbench

//  Parametrised multi-port integer register file with per-register busy scoreboard.

---
 rtl/reg_file_mp.sv | 91 +++++++++
 tb/tb_reg_file_mp.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// Purpose : multi-port integer register file (x0 hardwired zero) with a per-register busy scoreboard.
// Latency : reads are combinational from registered state; writes and issues take effect at the next clk edge.
// Backpr.  : none; every port is accepted every cycle. Optional feature macro: RF_WR_BYPASS_EN (write-to-read bypass).
module reg_file_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 1,
  localparam int IDX_W     = $clog2(NUM_REGS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR*IDX_W-1:0]      wr_idx,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
  input  logic [NUM_RD-1:0]            rd_en,
  input  logic [NUM_RD*IDX_W-1:0]      rd_idx,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_busy,
  input  logic                         issue_en,
  input  logic [IDX_W-1:0]             issue_idx,
  output logic [NUM_REGS-1:0]          busy_vec
);

  // Register 0 has no storage; the array starts at 1.
  logic [DATA_WIDTH-1:0] regs [1:NUM_REGS-1];
  logic [NUM_REGS-1:0]   busy_q;
  logic [NUM_REGS-1:0]   busy_nxt;

  // Next scoreboard: writebacks clear first, then an issue sets, so a same-cycle issue wins.
  always_comb begin
    busy_nxt = busy_q;
    for (int p = 0; p < NUM_WR; p++) begin
      if (wr_en[p]) begin
        busy_nxt[wr_idx[p*IDX_W +: IDX_W]] = 1'b0;
      end
    end
    if (issue_en) begin
      busy_nxt[issue_idx] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  // Register storage: reset loads reg i with i; ascending port loop lets the highest port win.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs[i] <= DATA_WIDTH'(i);
      end
    end else begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (wr_en[p] && (wr_idx[p*IDX_W +: IDX_W] != '0)) begin
          regs[wr_idx[p*IDX_W +: IDX_W]] <= wr_data[p*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Scoreboard state; reset discards everything pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_nxt;
    end
  end

  assign busy_vec = busy_q;

  // Read ports: disabled ports and index 0 drive zeros; optional bypass from this cycle's writes.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int q = 0; q < NUM_RD; q++) begin
      if (rd_en[q] && (rd_idx[q*IDX_W +: IDX_W] != '0)) begin
        rd_data[q*DATA_WIDTH +: DATA_WIDTH] = regs[rd_idx[q*IDX_W +: IDX_W]];
        rd_busy[q]                          = busy_q[rd_idx[q*IDX_W +: IDX_W]];
`ifdef RF_WR_BYPASS_EN
        // A matching write retires the register this cycle unless it is re-issued at the same time.
        for (int p = 0; p < NUM_WR; p++) begin
          if (wr_en[p] && (wr_idx[p*IDX_W +: IDX_W] == rd_idx[q*IDX_W +: IDX_W])) begin
            rd_data[q*DATA_WIDTH +: DATA_WIDTH] = wr_data[p*DATA_WIDTH +: DATA_WIDTH];
            rd_busy[q] = issue_en && (issue_idx == rd_idx[q*IDX_W +: IDX_W]);
          end
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Testbench for reg_file_mp: directed vectors, expectations queued by the driver and checked by a monitor.
module tb_reg_file_mp;
  localparam int DW  = 32;
  localparam int NR  = 32;
  localparam int NRD = 2;
  localparam int NWR = 2;
  localparam int IW  = 5;
`ifdef RF_WR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [NWR-1:0]    wr_en;
  logic [NWR*IW-1:0] wr_idx;
  logic [NWR*DW-1:0] wr_data;
  logic [NRD-1:0]    rd_en;
  logic [NRD*IW-1:0] rd_idx;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic              issue_en;
  logic [IW-1:0]     issue_idx;
  logic [NR-1:0]     busy_vec;

  always #5 clk = ~clk;

  reg_file_mp #(.DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_RD(NRD), .NUM_WR(NWR)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_data(rd_data), .rd_busy(rd_busy),
    .issue_en(issue_en), .issue_idx(issue_idx), .busy_vec(busy_vec)
  );

  typedef struct {
    string       name;
    int          port;
    logic [31:0] d;
    logic        b;
    bit          cbv;
    logic [31:0] bv;
  } exp_t;

  exp_t sb[$];
  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Disabled ports still carry a nonzero index so their zero outputs are meaningful.
  task automatic idle();
    wr_en     = '0;
    wr_idx    = '0;
    wr_data   = '0;
    rd_en     = '0;
    rd_idx    = {5'd5, 5'd5};
    issue_en  = 1'b0;
    issue_idx = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic wr(input int p, input int idx, input logic [31:0] d);
    wr_en[p]            = 1'b1;
    wr_idx[p*IW +: IW]  = idx[4:0];
    wr_data[p*DW +: DW] = d;
  endtask

  task automatic issue(input int idx);
    issue_en  = 1'b1;
    issue_idx = idx[4:0];
  endtask

  task automatic rd(input int q, input int idx, input logic [31:0] d, input logic b,
                    input string name, input bit cbv = 1'b0, input logic [31:0] bv = '0);
    exp_t e;
    rd_en[q]           = 1'b1;
    rd_idx[q*IW +: IW] = idx[4:0];
    e.name = name; e.port = q; e.d = d; e.b = b; e.cbv = cbv; e.bv = bv;
    sb.push_back(e);
  endtask

  // Monitor: every enabled read port pops one expectation; disabled ports must read as zero.
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      for (int q = 0; q < NRD; q++) begin
        if (rd_en[q]) begin
          if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_read port %0d: got data %h with no expectation queued", q, rd_data[q*DW +: DW]);
          end else begin
            e = sb.pop_front();
            chk({e.name, "_port"}, q, e.port);
            chk({e.name, "_data"}, rd_data[q*DW +: DW], e.d);
            chk({e.name, "_busy"}, {31'b0, rd_busy[q]}, {31'b0, e.b});
            if (e.cbv) chk({e.name, "_busy_vec"}, busy_vec, e.bv);
          end
        end else begin
          chk($sformatf("idle_rd%0d_data", q), rd_data[q*DW +: DW], 32'h0);
          chk($sformatf("idle_rd%0d_busy", q), {31'b0, rd_busy[q]}, 32'h0);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    idle();
    step();
    reset = 1'b0;

    // 1: reset contents
    rd(0, 5, 32'd5, 1'b0, "rst_r5", 1'b1, 32'h0);
    rd(1, 0, 32'd0, 1'b0, "rst_r0");
    step();
    rd(0, 31, 32'd31, 1'b0, "rst_r31");
    step();

    // 2: write then read; writes to x0 are dropped
    wr(0, 3, 32'hDEADBEEF);
    wr(1, 0, 32'h1);
    rd(0, 3, BYP ? 32'hDEADBEEF : 32'd3, 1'b0, "wr3_same");
    rd(1, 0, 32'd0, 1'b0, "wr0_same");
    step();
    rd(0, 3, 32'hDEADBEEF, 1'b0, "wr3_next");
    rd(1, 0, 32'd0, 1'b0, "wr0_next");
    step();

    // 3: both ports write reg 7, highest port wins
    wr(0, 7, 32'hA);
    wr(1, 7, 32'hB);
    rd(1, 7, BYP ? 32'hB : 32'd7, 1'b0, "dual7_same");
    step();
    rd(0, 7, 32'hB, 1'b0, "dual7_next");
    step();

    // 4: scoreboard set / clear / set-wins
    issue(9);
    rd(0, 9, 32'd9, 1'b0, "iss9_same");
    step();
    rd(0, 9, 32'd9, 1'b1, "iss9_next", 1'b1, 32'h200);
    step();
    wr(0, 9, 32'h99);
    rd(1, 9, BYP ? 32'h99 : 32'd9, BYP ? 1'b0 : 1'b1, "wb9_same", 1'b1, 32'h200);
    step();
    rd(0, 9, 32'h99, 1'b0, "wb9_next", 1'b1, 32'h0);
    step();
    issue(9);
    wr(1, 9, 32'h123);
    rd(0, 9, BYP ? 32'h123 : 32'h99, BYP ? 1'b1 : 1'b0, "isswb9_same");
    step();
    rd(0, 9, 32'h123, 1'b1, "isswb9_next_a", 1'b1, 32'h200);
    rd(1, 9, 32'h123, 1'b1, "isswb9_next_b");
    step();

    // 5: same-cycle write and read of reg 4
    wr(0, 4, 32'h55);
    rd(0, 4, BYP ? 32'h55 : 32'd4, 1'b0, "wr4_same");
    step();
    rd(0, 4, 32'h55, 1'b0, "wr4_next");
    step();

    // 6: reset beats write and issue in the same cycle, discarding prior state
    issue(2);
    wr(0, 6, 32'h77);
    reset = 1'b1;
    step();
    reset = 1'b0;
    rd(0, 6, 32'd6, 1'b0, "rst6", 1'b1, 32'h0);
    rd(1, 2, 32'd2, 1'b0, "rst2");
    step();
    rd(0, 3, 32'd3, 1'b0, "rst3");
    rd(1, 9, 32'd9, 1'b0, "rst9");
    step();

    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
